// File: rtl/lsu_rv32i_pkg.sv
// ============================================================================
// Module      : lsu_rv32i_pkg
// Description : Shared encodings for the RV32I load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_rv32i_pkg;

    // funct3 access-size encodings for LOAD/STORE
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int         STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

    // ALU operation types; the effective address is produced by ALU_OP_ADD
    localparam int         ALU_OP_W   = 4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'd9;

endpackage

`default_nettype wire

// File: rtl/lsu_align_rv32i.sv
// ============================================================================
// Module      : lsu_align_rv32i
// Description : Byte-lane steering, load extension and access legality checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align_rv32i
    import lsu_rv32i_pkg::*;
#(
    parameter int INT32W = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addrLsb_i,
    input  logic              isStore_i,
    input  logic [INT32W-1:0] storeData_i,
    input  logic [INT32W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [INT32W-1:0] wdata_o,
    output logic [INT32W-1:0] loadData_o,
    output logic              misaligned_o,
    output logic              illegal_o
);

    logic [INT32W-1:0] w_lane;

    assign w_lane = rdata_i >> {addrLsb_i, 3'b000};

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = storeData_i;
        loadData_o   = '0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o       = 4'b0001 << addrLsb_i;
                wdata_o    = {(INT32W/8){storeData_i[7:0]}};
                loadData_o = {{(INT32W-8){(funct3_i == F3_B) & w_lane[7]}}, w_lane[7:0]};
            end
            F3_H, F3_HU: begin
                be_o         = 4'b0011 << {addrLsb_i[1], 1'b0};
                wdata_o      = {(INT32W/16){storeData_i[15:0]}};
                loadData_o   = {{(INT32W-16){(funct3_i == F3_H) & w_lane[15]}}, w_lane[15:0]};
                misaligned_o = addrLsb_i[0];
            end
            F3_W: begin
                be_o         = 4'b1111;
                loadData_o   = w_lane;
                misaligned_o = |addrLsb_i;
            end
            default: illegal_o = 1'b1;
        endcase
        // Unsigned variants exist only for loads
        if (isStore_i && funct3_i[2])
            illegal_o = 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/lsu_rv32i.sv
// ============================================================================
// Module      : lsu_rv32i
// Description : Single-outstanding RV32I load/store unit with a req/gnt/rvalid bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_rv32i
    import lsu_rv32i_pkg::*;
#(
    parameter int INT32W = 32
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic              reqValidIn,
    output logic              reqReadyOut,
    input  logic              isStoreIn,
    input  logic [2:0]        funct3In,
    input  logic [INT32W-1:0] addrIn,
    input  logic [INT32W-1:0] storeDataIn,
    output logic              memReqOut,
    output logic              memWeOut,
    output logic [INT32W-1:0] memAddrOut,
    output logic [INT32W-1:0] memWdataOut,
    output logic [3:0]        memBeOut,
    input  logic              memGntIn,
    input  logic              memRvalidIn,
    input  logic [INT32W-1:0] memRdataIn,
    output logic              respValidOut,
    output logic [INT32W-1:0] loadDataOut,
    output logic              excOut
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               isStore_q, isStore_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [INT32W-1:0]  addr_q, addr_d;
    logic [INT32W-1:0]  sdata_q, sdata_d;
    logic [INT32W-1:0]  loadData_q, loadData_d;
    logic               exc_q, exc_d;

    logic               w_idle;
    logic [2:0]         w_funct3;
    logic [1:0]         w_addrLsb;
    logic               w_isStore;
    logic [INT32W-1:0]  w_sdata;
    logic [3:0]         w_be;
    logic [INT32W-1:0]  w_wdata;
    logic [INT32W-1:0]  w_loadData;
    logic               w_misaligned;
    logic               w_illegal;
    logic               w_bad;

    // One aligner serves both the IDLE legality check and the captured access
    assign w_idle    = (state_q == ST_IDLE);
    assign w_funct3  = w_idle ? funct3In         : funct3_q;
    assign w_addrLsb = w_idle ? addrIn[1:0]      : addr_q[1:0];
    assign w_isStore = w_idle ? isStoreIn        : isStore_q;
    assign w_sdata   = w_idle ? storeDataIn      : sdata_q;
    assign w_bad     = w_misaligned | w_illegal;

    lsu_align_rv32i #(
        .INT32W (INT32W)
    ) u_align (
        .funct3_i     (w_funct3),
        .addrLsb_i    (w_addrLsb),
        .isStore_i    (w_isStore),
        .storeData_i  (w_sdata),
        .rdata_i      (memRdataIn),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .loadData_o   (w_loadData),
        .misaligned_o (w_misaligned),
        .illegal_o    (w_illegal)
    );

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q    <= ST_IDLE;
            isStore_q  <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            sdata_q    <= '0;
            loadData_q <= '0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            isStore_q  <= isStore_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            loadData_q <= loadData_d;
            exc_q      <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (reqValidIn) state_d = w_bad ? ST_DONE : ST_REQ;
            ST_REQ:  if (memGntIn)   state_d = isStore_q ? ST_DONE : ST_WAIT;
            ST_WAIT: if (memRvalidIn) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        isStore_d  = isStore_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        loadData_d = loadData_q;
        exc_d      = exc_q;
        if (w_idle && reqValidIn) begin
            isStore_d  = isStoreIn;
            funct3_d   = funct3In;
            addr_d     = addrIn;
            sdata_d    = storeDataIn;
            loadData_d = '0;
            exc_d      = w_bad;
        end else if ((state_q == ST_WAIT) && memRvalidIn) begin
            loadData_d = w_loadData;
        end
    end

    // Bus and response outputs are gated by state so an async reset clears them at once
    always_comb begin
        reqReadyOut  = w_idle;
        memReqOut    = (state_q == ST_REQ);
        memWeOut     = memReqOut & isStore_q;
        memAddrOut   = memReqOut ? {addr_q[INT32W-1:2], 2'b00} : '0;
        memBeOut     = memReqOut ? w_be : 4'b0000;
        memWdataOut  = memWeOut ? w_wdata : '0;
        respValidOut = (state_q == ST_DONE);
        excOut       = respValidOut & exc_q;
        loadDataOut  = respValidOut ? loadData_q : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_rv32i.sv
// ============================================================================
// Module      : tb_lsu_rv32i
// Description : Self-checking bench for lsu_rv32i against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_rv32i;

    logic        clk;
    logic        rst;
    logic        reqValidIn;
    logic        reqReadyOut;
    logic        isStoreIn;
    logic [2:0]  funct3In;
    logic [31:0] addrIn;
    logic [31:0] storeDataIn;
    logic        memReqOut;
    logic        memWeOut;
    logic [31:0] memAddrOut;
    logic [31:0] memWdataOut;
    logic [3:0]  memBeOut;
    logic        memGntIn;
    logic        memRvalidIn;
    logic [31:0] memRdataIn;
    logic        respValidOut;
    logic [31:0] loadDataOut;
    logic        excOut;

    int checks = 0;
    int errors = 0;

    lsu_rv32i #(.INT32W(32)) dut (
        .clkIn        (clk),
        .rstIn        (rst),
        .reqValidIn   (reqValidIn),
        .reqReadyOut  (reqReadyOut),
        .isStoreIn    (isStoreIn),
        .funct3In     (funct3In),
        .addrIn       (addrIn),
        .storeDataIn  (storeDataIn),
        .memReqOut    (memReqOut),
        .memWeOut     (memWeOut),
        .memAddrOut   (memAddrOut),
        .memWdataOut  (memWdataOut),
        .memBeOut     (memBeOut),
        .memGntIn     (memGntIn),
        .memRvalidIn  (memRvalidIn),
        .memRdataIn   (memRdataIn),
        .respValidOut (respValidOut),
        .loadDataOut  (loadDataOut),
        .excOut       (excOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference model: access rules expressed as plain arithmetic
    function automatic bit m_bad(input bit st, input int f3, input logic [31:0] a);
        int k = int'(a % 4);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
        if (st && f3 >= 4) return 1;
        if ((f3 == 1 || f3 == 5) && (k % 2) != 0) return 1;
        if (f3 == 2 && k != 0) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input int f3, input logic [31:0] a);
        int k = int'(a % 4);
        if (f3 == 0 || f3 == 4) return 4'(1 << k);
        if (f3 == 1 || f3 == 5) return 4'(3 << (k - k % 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
        if (f3 == 0) return (d % 256) * 32'h0101_0101;
        if (f3 == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] r);
        longint v = longint'(r / (32'd1 << (8 * (a % 4))));
        longint b = v % 256;
        longint h = v % 65536;
        case (f3)
            0: return 32'(b >= 128 ? b - 256 : b);
            4: return 32'(b);
            1: return 32'(h >= 32768 ? h - 65536 : h);
            5: return 32'(h);
            default: return r;
        endcase
    endfunction

    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rdv,
                           input int gd, input int rdl, input string nm);
        bit          bad    = m_bad(st, int'(f3), a);
        logic [31:0] e_addr = a & 32'hFFFF_FFFC;
        logic [3:0]  e_be   = m_be(int'(f3), a);
        logic [31:0] e_wd   = m_wdata(int'(f3), d);
        logic [31:0] e_ld   = (st || bad) ? 32'h0 : m_load(int'(f3), a, rdv);
        checks++;
        if (reqReadyOut !== 1'b1) begin
            errors++; $display("FAIL %s ready_idle got %b exp 1", nm, reqReadyOut);
        end
        reqValidIn = 1'b1; isStoreIn = st; funct3In = f3; addrIn = a; storeDataIn = d;
        @(posedge clk); #1;
        reqValidIn = 1'b0; isStoreIn = 1'($urandom); funct3In = 3'($urandom);
        addrIn = $urandom; storeDataIn = $urandom;
        if (bad) begin
            checks++;
            if (memReqOut !== 1'b0 || respValidOut !== 1'b1 || excOut !== 1'b1 || loadDataOut !== 32'h0) begin
                errors++;
                $display("FAIL %s exc_resp got req=%b resp=%b exc=%b ld=%h exp req=0 resp=1 exc=1 ld=0",
                         nm, memReqOut, respValidOut, excOut, loadDataOut);
            end
        end else begin
            for (int i = 0; i <= gd; i++) begin
                checks++;
                if (memReqOut !== 1'b1 || reqReadyOut !== 1'b0 || memAddrOut !== e_addr ||
                    memWeOut !== st || memBeOut !== e_be || respValidOut !== 1'b0) begin
                    errors++;
                    $display("FAIL %s req_phase cyc%0d got req=%b rdy=%b addr=%h we=%b be=%b resp=%b exp req=1 rdy=0 addr=%h we=%b be=%b resp=0",
                             nm, i, memReqOut, reqReadyOut, memAddrOut, memWeOut, memBeOut, respValidOut,
                             e_addr, st, e_be);
                end
                if (st) begin
                    checks++;
                    if (memWdataOut !== e_wd) begin
                        errors++; $display("FAIL %s wdata got %h exp %h", nm, memWdataOut, e_wd);
                    end
                end
                memGntIn = (i == gd);
                memRvalidIn = 1'b1;
                memRdataIn = $urandom;
                @(posedge clk); #1;
            end
            memGntIn = 1'b0; memRvalidIn = 1'b0;
            if (!st) begin
                for (int i = 0; i <= rdl; i++) begin
                    checks++;
                    if (memReqOut !== 1'b0 || respValidOut !== 1'b0 || reqReadyOut !== 1'b0) begin
                        errors++;
                        $display("FAIL %s wait_phase cyc%0d got req=%b resp=%b rdy=%b exp 0 0 0",
                                 nm, i, memReqOut, respValidOut, reqReadyOut);
                    end
                    memRvalidIn = (i == rdl);
                    memRdataIn = (i == rdl) ? rdv : $urandom;
                    @(posedge clk); #1;
                end
                memRvalidIn = 1'b0; memRdataIn = $urandom;
            end
            checks++;
            if (respValidOut !== 1'b1 || excOut !== 1'b0 || loadDataOut !== e_ld || memReqOut !== 1'b0) begin
                errors++;
                $display("FAIL %s done got resp=%b exc=%b ld=%h req=%b exp resp=1 exc=0 ld=%h req=0",
                         nm, respValidOut, excOut, loadDataOut, memReqOut, e_ld);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (respValidOut !== 1'b0 || reqReadyOut !== 1'b1 || excOut !== 1'b0) begin
            errors++;
            $display("FAIL %s back_idle got resp=%b rdy=%b exc=%b exp 0 1 0", nm, respValidOut, reqReadyOut, excOut);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; reqValidIn = 1'b0; isStoreIn = 1'b0; funct3In = 3'b000; addrIn = '0;
        storeDataIn = '0; memGntIn = 1'b0; memRvalidIn = 1'b0; memRdataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({memReqOut, memWeOut, memBeOut, respValidOut, excOut} !== 8'h0 ||
            loadDataOut !== 32'h0 || memAddrOut !== 32'h0 || memWdataOut !== 32'h0 || reqReadyOut !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got req=%b we=%b be=%b resp=%b exc=%b ld=%h addr=%h wd=%h rdy=%b exp all 0 rdy=1",
                     memReqOut, memWeOut, memBeOut, respValidOut, excOut, loadDataOut, memAddrOut, memWdataOut, reqReadyOut);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, "sw_0x100");
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, "lb_0x103");
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, "lbu_0x103");
        run_txn(1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 0, 0, "sh_0x102");
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 0, 0, "lhu_0x102");
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0, 0, "lh_0x102");
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, "lw_misaligned");
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, "f3_011_illegal");
        run_txn(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 0, "sbu_illegal");
        run_txn(1'b0, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0, "lh_misaligned");
    endtask

    task automatic test_delayed();
        run_txn(1'b0, 3'b010, 32'h0000_4440, 32'h0, 32'hCAFE_F00D, 3, 2, "lw_delayed");
        run_txn(1'b1, 3'b000, 32'h0000_7771, 32'h0000_00A5, 32'h0, 3, 0, "sb_delayed");
    endtask

    task automatic test_reset_midflight();
        reqValidIn = 1'b1; isStoreIn = 1'b0; funct3In = 3'b010; addrIn = 32'h300; storeDataIn = '0;
        @(posedge clk); #1;
        reqValidIn = 1'b0; memGntIn = 1'b1;
        @(posedge clk); #1;
        memGntIn = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({memReqOut, memWeOut, memBeOut, respValidOut, excOut} !== 8'h0 ||
            loadDataOut !== 32'h0 || memAddrOut !== 32'h0 || memWdataOut !== 32'h0) begin
            errors++;
            $display("FAIL rst_in_wait got req=%b resp=%b exc=%b ld=%h addr=%h exp all 0",
                     memReqOut, respValidOut, excOut, loadDataOut, memAddrOut);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        memRvalidIn = 1'b1; memRdataIn = 32'h1234_5678;
        @(posedge clk); #1;
        memRvalidIn = 1'b0;
        checks++;
        if (respValidOut !== 1'b0 || reqReadyOut !== 1'b1 || loadDataOut !== 32'h0) begin
            errors++;
            $display("FAIL stale_rvalid got resp=%b rdy=%b ld=%h exp 0 1 0", respValidOut, reqReadyOut, loadDataOut);
        end
        run_txn(1'b0, 3'b000, 32'h301, 32'h0, 32'h0000_7F00, 0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 3'b000, 32'h10, 32'h0000_00EE, 32'h0, 0, 0, "b2b_sb");
        run_txn(1'b0, 3'b000, 32'h12, 32'h0, 32'h00AB_0000, 0, 0, "b2b_lb");
        run_txn(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 0, 0, "b2b_exc");
        run_txn(1'b1, 3'b010, 32'h14, 32'h0BAD_F00D, 32'h0, 0, 0, "b2b_sw");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit          st  = 1'($urandom);
            logic [2:0]  f3  = 3'($urandom);
            logic [31:0] a   = $urandom;
            logic [31:0] d   = $urandom;
            logic [31:0] rdv = $urandom;
            // Bias toward legal sizes so most transactions reach the bus
            if ($urandom_range(3) != 0) f3 = (st) ? 3'($urandom_range(2)) : 3'($urandom_range(5));
            if ($urandom_range(1) != 0) a = a & ~((f3[1:0] == 2'b10) ? 32'h3 : (f3[0] ? 32'h1 : 32'h0));
            run_txn(st, f3, a, d, rdv, int'($urandom_range(3)), int'($urandom_range(3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_delayed();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
